// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// AlUop codes, FSM state encoding and datapath widths.
package muldiv_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake bundle between the pipeline and the
// multi-cycle multiply/divide sequencer.
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic            start;
  logic [4:0]      aluop;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, aluop, op_a, op_b, flush,
    input  busy, stall_req, done, result
  );

  modport slave (
    input  start, aluop, op_a, op_b, flush,
    output busy, stall_req, done, result
  );

endinterface

// File: rtl/muldiv_sequencer_iter_datapath.sv
// Operand registers, shared 2*XLEN accumulator and one-bit-per-step
// shift-add multiply / restoring divide with final sign fix-up.
module muldiv_iter_datapath
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            prep,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            div_zero,
  output logic            ovf,
  output logic [XLEN-1:0] special,
  output logic [XLEN-1:0] fix_res
);

  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   rb_q, rb_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic              is_div, is_rem, uns;
  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_ext;
  logic              ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    is_div = op_q[2];
    is_rem = op_q[2] & op_q[1];
    uns    = op_q[0];
    a_sgn  = is_div ? !uns
           : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
    b_sgn  = is_div ? !uns : (op_q[1:0] == 2'b01);
    sa     = a_sgn & ra_q[XLEN-1];
    sb     = b_sgn & rb_q[XLEN-1];
    abs_a  = sa ? -ra_q : ra_q;
    abs_b  = sb ? -rb_q : rb_q;

    div_zero = is_div & (rb_q == '0);
    ovf      = is_div & !uns & (ra_q == INT_MIN)
             & (rb_q == '1);
    if (div_zero)
      special = is_rem ? ra_q : '1;
    else
      special = is_rem ? '0 : INT_MIN;

    // add-then-shift: multiplier sits in the low half
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
        + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_nxt = {sum, acc_q[XLEN-1:1]};

    // remainder may briefly need XLEN+1 bits after the shift
    rem_ext = acc_q[2*XLEN-1:XLEN-1];
    ge      = rem_ext >= {1'b0, m_q};
    div_nxt = ge
      ? {rem_ext[XLEN-1:0] - m_q, acc_q[XLEN-2:0], 1'b1}
      : {acc_q[2*XLEN-2:0], 1'b0};

    prod = negq_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (!is_div)
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
              : prod[2*XLEN-1:XLEN];
    else if (is_rem)
      fix_res = negr_q ? -rem : rem;
    else
      fix_res = negq_q ? -quo : quo;
  end

  always_comb begin
    op_d   = op_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    m_d    = m_q;
    acc_d  = acc_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (load) begin
      op_d = op;
      ra_d = op_a;
      rb_d = op_b;
    end else if (prep) begin
      m_d    = is_div ? abs_b : abs_a;
      acc_d  = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
      negq_d = sa ^ sb;
      negr_d = sa;
    end else if (step) begin
      acc_d = is_div ? div_nxt : mul_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage RV32M sequencer: FSM that drives the iterative datapath
// and stalls the pipeline until the result is ready.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  muldiv_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              m_op;
  logic              load, prep, step;
  logic              div_zero, ovf;
  logic [XLEN-1:0]   special, fix_res;

  assign m_op = bus.aluop[4:3] == 2'b01;

  muldiv_iter_datapath u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .prep     (prep),
    .step     (step),
    .op       (bus.aluop[2:0]),
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .div_zero (div_zero),
    .ovf      (ovf),
    .special  (special),
    .fix_res  (fix_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    load     = 1'b0;
    prep     = 1'b0;
    step     = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && m_op) begin
            load    = 1'b1;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          prep = 1'b1;
          if (div_zero || ovf) begin
            result_d = special;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          step = 1'b1;
          if (cnt_q == '0)
            state_d = S_FIX;
          else
            cnt_d = cnt_q - 1'b1;
        end
        S_FIX: begin
          result_d = fix_res;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.stall_req =
    (state_q == S_IDLE && bus.start && m_op && !bus.flush)
    || state_q == S_PREP
    || state_q == S_ITER
    || state_q == S_FIX;

endmodule
